mini_src_control_unit: RTL

Multi-cycle Moore control sequencer for the Mini-SRC datapath. It steps fetch, decode and execute for a fixed instruction subset. It drives the register select/encode strobes (Gra/Grb/Grc/Rin/Rout/BAout), the bus-out and register-in enables, memory Read/Write and the ALU operation code. The opcode comes from IR[31:27].

---
 rtl/mini_src_control_unit_if.sv | 49 ++++
 rtl/mini_src_control_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mini_src_control_unit_if.sv
// -----------------------------------------------------------------------------
// mini_src_control_unit_if
//
// Control bundle between the Mini-SRC control sequencer and its datapath.
//
// Signals:
//   ir[31:0]        instruction register contents (opcode = ir[31:27])
//   con_ff          branch condition flip-flop output
//   mem_ready       memory done strobe (only observed when MEM_WAIT_EN is set)
//   Gra/Grb/Grc     register field select strobes
//   Rin/Rout/BAout  register file load / drive / base-address drive
//   PCout, Zlowout, MDRout, Cout                 bus drivers
//   PCin, IRin, MARin, MDRin, Yin, Zin, CONin    register loads
//   IncPC, Read, Write                           PC increment, memory strobes
//   alu_op[4:0]     ALU operation code (opcode encoding)
//   run             high unless the sequencer is halted
//
// Modports:
//   master - the control unit (drives the strobes, reads ir/con_ff/mem_ready)
//   slave  - the datapath side
// -----------------------------------------------------------------------------
interface mini_src_control_unit_if;
    logic [31:0] ir;
    logic        con_ff;
    logic        mem_ready;

    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        PCout, Zlowout, MDRout, Cout;
    logic        PCin, IRin, MARin, MDRin, Yin, Zin, CONin;
    logic        IncPC, Read, Write;
    logic [4:0]  alu_op;
    logic        run;

    modport master (
        input  ir, con_ff, mem_ready,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output PCout, Zlowout, MDRout, Cout,
        output PCin, IRin, MARin, MDRin, Yin, Zin, CONin,
        output IncPC, Read, Write, alu_op, run
    );

    modport slave (
        output ir, con_ff, mem_ready,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  PCout, Zlowout, MDRout, Cout,
        input  PCin, IRin, MARin, MDRin, Yin, Zin, CONin,
        input  IncPC, Read, Write, alu_op, run
    );
endinterface

// File: rtl/mini_src_control_unit.sv
// -----------------------------------------------------------------------------
// mini_src_control_unit
//
// Multi-cycle Moore control sequencer for the Mini-SRC datapath. Steps fetch
// (T0..T2), decode and execute (T3..T7) for ld, st, add, sub, and, or, addi,
// andi, ori, br, nop and halt. Unknown opcodes run as nop. halt parks the
// sequencer in HALT until reset.
//
// Ports:
//   clock  in  rising-edge system clock
//   reset  in  synchronous active-high reset; while high every output is 0
//   bus    mini_src_control_unit_if.master (ir/con_ff/mem_ready in, strobes out)
//
// Parameters:
//   OP_W   opcode width, taken from the top of ir (fixed at 5)
//
// Optional feature (macro MEM_WAIT_EN):
//   When defined, fetch T1, ld T6 and st T7 hold (outputs held) until a cycle
//   with mem_ready=1, advancing on that edge. When undefined, each memory step
//   takes exactly one cycle and mem_ready is ignored.
//
// Outputs are decoded combinationally from the state register and the opcode:
// the opcode only becomes valid in T3 (IR loads at the end of T2) and reset
// must blank the outputs in the same cycle it is asserted.
// -----------------------------------------------------------------------------
module mini_src_control_unit #(
    parameter int OP_W = 5
) (
    input  logic                          clock,
    input  logic                          reset,
    mini_src_control_unit_if.master       bus
);

    typedef enum logic [3:0] {
        ST_T0   = 4'd0,
        ST_T1   = 4'd1,
        ST_T2   = 4'd2,
        ST_T3   = 4'd3,
        ST_T4   = 4'd4,
        ST_T5   = 4'd5,
        ST_T6   = 4'd6,
        ST_T7   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    state_t          state_q, state_d;
    logic [OP_W-1:0] opcode;
    logic            is_alu, is_imm, is_ld, is_st, is_br, is_halt;
    logic            mem_go;

    // Immediate ops reuse the register-form ALU codes.
    function automatic logic [OP_W-1:0] imm_alu_code(input logic [OP_W-1:0] op);
        case (op)
            OP_ANDI: imm_alu_code = OP_AND;
            OP_ORI:  imm_alu_code = OP_OR;
            default: imm_alu_code = OP_ADD;
        endcase
    endfunction

    assign opcode = bus.ir[31:32-OP_W];

    // Only the opcode field steers the sequencer; register fields and the
    // constant belong to the datapath.
    logic unused_ir_fields;
    assign unused_ir_fields = ^bus.ir[31-OP_W:0];

    assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
    assign is_imm  = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign is_ld   = (opcode == OP_LD);
    assign is_st   = (opcode == OP_ST);
    assign is_br   = (opcode == OP_BR);
    assign is_halt = (opcode == OP_HALT);

`ifdef MEM_WAIT_EN
    assign mem_go = bus.mem_ready;
`else
    assign mem_go = 1'b1;
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_T0: state_d = ST_T1;
            ST_T1: state_d = mem_go ? ST_T2 : ST_T1;
            ST_T2: state_d = ST_T3;
            ST_T3: begin
                if (is_alu || is_imm || is_ld || is_st || is_br) state_d = ST_T4;
                else if (is_halt)                                state_d = ST_HALT;
                else                                             state_d = ST_T0;
            end
            ST_T4: state_d = ST_T5;
            ST_T5: state_d = (is_ld || is_st || is_br) ? ST_T6 : ST_T0;
            ST_T6: begin
                if (is_ld)      state_d = mem_go ? ST_T7 : ST_T6;
                else if (is_st) state_d = ST_T7;
                else            state_d = ST_T0;
            end
            ST_T7:   state_d = (is_st && !mem_go) ? ST_T7 : ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_T0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_T0;
        else       state_q <= state_d;
    end

    always_comb begin
        bus.Gra = 1'b0;  bus.Grb = 1'b0;  bus.Grc = 1'b0;
        bus.Rin = 1'b0;  bus.Rout = 1'b0; bus.BAout = 1'b0;
        bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.MDRout = 1'b0; bus.Cout = 1'b0;
        bus.PCin = 1'b0; bus.IRin = 1'b0; bus.MARin = 1'b0; bus.MDRin = 1'b0;
        bus.Yin = 1'b0;  bus.Zin = 1'b0;  bus.CONin = 1'b0;
        bus.IncPC = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0;
        bus.alu_op = '0;
        bus.run = 1'b0;

        // Reset blanks everything in the same cycle so an interrupted
        // instruction cannot complete a register or memory write.
        if (!reset) begin
            bus.run = (state_q != ST_HALT);
            case (state_q)
                ST_T0: begin
                    bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
                end
                ST_T1: begin
                    bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
                end
                ST_T2: begin
                    bus.MDRout = 1'b1; bus.IRin = 1'b1;
                end
                ST_T3: begin
                    if (is_alu || is_imm) begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                    end else if (is_ld || is_st) begin
                        bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
                    end else if (is_br) begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
                    end
                end
                ST_T4: begin
                    if (is_alu) begin
                        bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
                        bus.alu_op = opcode;
                    end else if (is_imm) begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1;
                        bus.alu_op = imm_alu_code(opcode);
                    end else if (is_ld || is_st) begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1;
                        bus.alu_op = OP_ADD;
                    end else if (is_br) begin
                        bus.PCout = 1'b1; bus.Yin = 1'b1;
                    end
                end
                ST_T5: begin
                    if (is_alu || is_imm) begin
                        bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                    end else if (is_ld || is_st) begin
                        bus.Zlowout = 1'b1; bus.MARin = 1'b1;
                    end else if (is_br) begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1;
                        bus.alu_op = OP_ADD;
                    end
                end
                ST_T6: begin
                    if (is_ld) begin
                        bus.Read = 1'b1; bus.MDRin = 1'b1;
                    end else if (is_st) begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
                    end else if (is_br) begin
                        // Branch target is taken only if the condition holds now.
                        bus.Zlowout = 1'b1; bus.PCin = bus.con_ff;
                    end
                end
                ST_T7: begin
                    if (is_ld) begin
                        bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                    end else if (is_st) begin
                        bus.Write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
